// File: rtl/gun_pkg.sv
// Shared types and constants for the light-gun crosshair controller.
package gun_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    SLOW  = 2'd2,
    FAST  = 2'd3
  } axis_state_t;

  localparam int GUN_W        = 6;
  localparam int POS_MAX_DEF  = 62;
  localparam int POS_INIT_DEF = 31;

  // Width of a tick counter able to hold the largest of the three delays.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

  // One saturating step of a 6-bit coordinate.
  function automatic logic [GUN_W-1:0] clamp_step(input logic [GUN_W-1:0] pos,
                                                  input logic              inc,
                                                  input logic [GUN_W-1:0] pmax);
    if (inc) return (pos >= pmax) ? pmax : pos + 6'd1;
    else     return (pos == '0)   ? '0   : pos - 6'd1;
  endfunction

endpackage

// File: rtl/gun_axis_ctrl_if.sv
// Joystick / crosshair signal bundle of the gun controller.
interface gun_axis_ctrl_if;
  import gun_pkg::*;

  logic             tick_4ms;
  logic             enable;
  logic             recenter;
  logic             left;
  logic             right;
  logic             up;
  logic             down;
  logic [GUN_W-1:0] gun_h;
  logic [GUN_W-1:0] gun_v;
  logic             moving;
  logic             step_strobe;

  modport master (
    output tick_4ms, enable, recenter, left, right, up, down,
    input  gun_h, gun_v, moving, step_strobe
  );

  modport slave (
    input  tick_4ms, enable, recenter, left, right, up, down,
    output gun_h, gun_v, moving, step_strobe
  );

endinterface

// File: rtl/gun_axis.sv
// One crosshair axis: press / first-repeat / slow / fast stepping FSM with a
// saturating 6-bit position. GUN_ACCEL_EN enables the FAST state and hold_cnt.
module gun_axis import gun_pkg::*; #(
  parameter int POS_MAX     = POS_MAX_DEF,
  parameter int POS_INIT    = POS_INIT_DEF,
  parameter int FIRST_DELAY = 8,
  parameter int SLOW_DIV    = 4,
  parameter int ACCEL_TICKS = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic             dec_i,
  input  logic             inc_i,
  input  logic             clear_i,
  input  logic             hold_i,
  output logic [GUN_W-1:0] pos_o,
  output logic             stepped_o,
  output logic             active_o
);

  localparam int              CW      = cnt_width(FIRST_DELAY, SLOW_DIV, ACCEL_TICKS);
  localparam logic [GUN_W-1:0] PMAX    = GUN_W'(POS_MAX);
  localparam logic [GUN_W-1:0] PINIT   = GUN_W'(POS_INIT);
  localparam logic [CW-1:0]    FD_LAST = CW'(FIRST_DELAY - 1);
  localparam logic [CW-1:0]    SD_LAST = CW'(SLOW_DIV - 1);

  axis_state_t      state_q, state_d;
  logic [GUN_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;       // latched direction, 1 = increment
  logic [CW-1:0]    div_q, div_d;
  logic             stepped_q, stepped_d;
  logic             do_step, step_inc, has_dir;

`ifdef GUN_ACCEL_EN
  localparam logic [CW-1:0] ACCEL_LIM = CW'(ACCEL_TICKS);
  logic [CW-1:0] hold_q, hold_d, hold_inc;
  assign hold_inc = (hold_q >= ACCEL_LIM) ? hold_q : hold_q + 1'b1;
`endif

  assign has_dir = dec_i ^ inc_i;

  // Next-state decode: clear beats hold beats tick; a press or reversal steps at once.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    dir_d     = dir_q;
    div_d     = div_q;
    stepped_d = 1'b0;
    do_step   = 1'b0;
    step_inc  = dir_q;
`ifdef GUN_ACCEL_EN
    hold_d    = hold_q;
`endif
    if (clear_i) begin
      state_d = IDLE;
      pos_d   = PINIT;
      div_d   = '0;
`ifdef GUN_ACCEL_EN
      hold_d  = '0;
`endif
    end else if (hold_i) begin
      state_d = IDLE;
      div_d   = '0;
`ifdef GUN_ACCEL_EN
      hold_d  = '0;
`endif
    end else if (tick_i) begin
      if (!has_dir) begin
        state_d = IDLE;
        div_d   = '0;
`ifdef GUN_ACCEL_EN
        hold_d  = '0;
`endif
      end else if (state_q == IDLE || inc_i != dir_q) begin
        do_step  = 1'b1;
        step_inc = inc_i;
        dir_d    = inc_i;
        state_d  = FIRST;
        div_d    = '0;
`ifdef GUN_ACCEL_EN
        hold_d   = '0;
`endif
      end else begin
        case (state_q)
          FIRST: begin
            if (div_q == FD_LAST) begin
              do_step = 1'b1;
              state_d = SLOW;
              div_d   = '0;
            end else begin
              div_d = div_q + 1'b1;
            end
          end
          SLOW: begin
`ifdef GUN_ACCEL_EN
            hold_d = hold_inc;
`endif
            if (div_q == SD_LAST) begin
              do_step = 1'b1;
              div_d   = '0;
`ifdef GUN_ACCEL_EN
              if (hold_inc >= ACCEL_LIM) state_d = FAST;
`endif
            end else begin
              div_d = div_q + 1'b1;
            end
          end
          FAST:    do_step = 1'b1;
          default: state_d = IDLE;
        endcase
      end
      if (do_step) begin
        pos_d     = clamp_step(pos_q, step_inc, PMAX);
        stepped_d = (pos_d != pos_q);
      end
    end
  end

  // FSM, position and repeat-divider registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      pos_q     <= PINIT;
      dir_q     <= 1'b0;
      div_q     <= '0;
      stepped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      div_q     <= div_d;
      stepped_q <= stepped_d;
    end
  end

`ifdef GUN_ACCEL_EN
  // Ticks spent in SLOW, saturating at the acceleration threshold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) hold_q <= '0;
    else         hold_q <= hold_d;
  end
`endif

  assign pos_o     = pos_q;
  assign stepped_o = stepped_q;
  assign active_o  = (state_q != IDLE);

endmodule

// File: rtl/gun_axis_ctrl.sv
// Turkey Shoot light-gun controller: converts joystick bits into gun_h/gun_v,
// paced by the rising edge of the game's 4 ms tick. Optional macro
// GUN_ACCEL_EN adds the FAST auto-repeat state to both axes.
module gun_axis_ctrl import gun_pkg::*; #(
  parameter int POS_MAX     = POS_MAX_DEF,
  parameter int POS_INIT    = POS_INIT_DEF,
  parameter int FIRST_DELAY = 8,
  parameter int SLOW_DIV    = 4,
  parameter int ACCEL_TICKS = 32
) (
  input logic             clock_12,
  input logic             reset_n,
  gun_axis_ctrl_if.slave  bus
);

  logic             tick_q, tick_d, tick;
  logic             clear, hold;
  logic [GUN_W-1:0] h_pos, v_pos;
  logic             h_stepped, v_stepped, h_active, v_active;

  // tick_q resets high so a tick already high at reset release is not an edge;
  // it keeps tracking while disabled so re-enabling cannot fake an edge.
  assign tick_d = bus.tick_4ms;
  always_ff @(posedge clock_12 or negedge reset_n) begin
    if (!reset_n) tick_q <= 1'b1;
    else          tick_q <= tick_d;
  end

  assign tick  = bus.tick_4ms & ~tick_q;
  assign clear = bus.recenter;
  assign hold  = ~bus.enable;

  gun_axis #(
    .POS_MAX(POS_MAX), .POS_INIT(POS_INIT), .FIRST_DELAY(FIRST_DELAY),
    .SLOW_DIV(SLOW_DIV), .ACCEL_TICKS(ACCEL_TICKS)
  ) u_h (
    .clk_i(clock_12), .rst_ni(reset_n), .tick_i(tick),
    .dec_i(bus.left), .inc_i(bus.right), .clear_i(clear), .hold_i(hold),
    .pos_o(h_pos), .stepped_o(h_stepped), .active_o(h_active)
  );

  gun_axis #(
    .POS_MAX(POS_MAX), .POS_INIT(POS_INIT), .FIRST_DELAY(FIRST_DELAY),
    .SLOW_DIV(SLOW_DIV), .ACCEL_TICKS(ACCEL_TICKS)
  ) u_v (
    .clk_i(clock_12), .rst_ni(reset_n), .tick_i(tick),
    .dec_i(bus.up), .inc_i(bus.down), .clear_i(clear), .hold_i(hold),
    .pos_o(v_pos), .stepped_o(v_stepped), .active_o(v_active)
  );

  assign bus.gun_h       = h_pos;
  assign bus.gun_v       = v_pos;
  assign bus.step_strobe = h_stepped | v_stepped;
  assign bus.moving      = h_active | v_active;

endmodule
